// File: rtl/geofence_collector.sv
// rtl/geofence_collector.sv - collects per-object geofence verdicts into an indexed FWFT result FIFO with counters
module geofence_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic                     is_inside,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_idx,
    output logic                     out_inside,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         inside_cnt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [LW-1:0]    LVL_ONE = LW'(1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] mem_idx    [DEPTH];
    logic             mem_inside [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    // A pop frees a slot on the same edge, so a full FIFO still takes the push.
    assign do_pop  = !clear && !empty && out_ready;
    assign do_push = !clear && valid && (!full || do_pop);
    assign drop    = !clear && valid && full && !do_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            total_cnt  <= '0;
            inside_cnt <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            total_cnt  <= '0;
            inside_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // Dropped results still count: the index tracks objects evaluated, not stored.
            if (valid) begin
                total_cnt <= total_cnt + CNT_ONE;
                if (is_inside && (inside_cnt != CNT_MAX)) begin
                    inside_cnt <= inside_cnt + CNT_ONE;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_idx[wr_ptr]    <= total_cnt;
            mem_inside[wr_ptr] <= is_inside;
        end
    end

    // Storage is not reset; gating on empty keeps the head outputs at zero in reset and after clear.
    assign out_valid  = !empty;
    assign out_idx    = empty ? '0 : mem_idx[rd_ptr];
    assign out_inside = empty ? 1'b0 : mem_inside[rd_ptr];

endmodule

// File: tb/tb_geofence_collector.sv
// tb/tb_geofence_collector.sv - vector table plus scoreboard bench for geofence_collector
module tb_geofence_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic       is_inside;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_idx;
    logic       out_inside;
    logic [7:0] total_cnt;
    logic [7:0] inside_cnt;
    logic [2:0] level;
    logic       overflow;

    logic       w_out_valid;
    logic [3:0] w_out_idx;
    logic       w_out_inside;
    logic [3:0] w_total_cnt;
    logic [3:0] w_inside_cnt;
    logic [2:0] w_level;
    logic       w_overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    geofence_collector #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .is_inside(is_inside), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_inside(out_inside),
        .total_cnt(total_cnt), .inside_cnt(inside_cnt), .level(level), .overflow(overflow)
    );

    geofence_collector #(.DEPTH(4), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .valid(valid), .is_inside(is_inside), .clear(clear),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_idx(w_out_idx), .out_inside(w_out_inside),
        .total_cnt(w_total_cnt), .inside_cnt(w_inside_cnt), .level(w_level), .overflow(w_overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected entries queued as the stimulus is applied, compared when the head is consumed.
    typedef struct {
        int idx;
        int ins;
    } ent_t;

    ent_t mq[$];
    int   m_total  = 0;
    int   m_inside = 0;
    int   m_ovf    = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            m_total  = 0;
            m_inside = 0;
            m_ovf    = 0;
            chk("sb_reset_out_valid", out_valid, 0);
            chk("sb_reset_level", level, 0);
        end else begin
            chk("sb_out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
            chk("sb_level", level, mq.size());
            chk("sb_total_cnt", total_cnt, m_total);
            chk("sb_inside_cnt", inside_cnt, m_inside);
            chk("sb_overflow", overflow, m_ovf);
            if (out_valid && out_ready && mq.size() != 0) begin
                chk("sb_pop_idx", out_idx, mq[0].idx);
                chk("sb_pop_inside", out_inside, mq[0].ins);
            end
            if (clear) begin
                mq.delete();
                m_total  = 0;
                m_inside = 0;
                m_ovf    = 0;
            end else begin
                if (mq.size() != 0 && out_ready) begin
                    void'(mq.pop_front());
                end
                if (valid) begin
                    if (mq.size() < 4) begin
                        mq.push_back('{idx: m_total % 256, ins: is_inside ? 1 : 0});
                    end else begin
                        m_ovf = 1;
                    end
                    m_total = (m_total + 1) % 256;
                    if (is_inside && m_inside != 255) begin
                        m_inside = m_inside + 1;
                    end
                end
            end
        end
    end

    typedef struct {
        logic v;
        logic ins;
        logic rdy;
        logic clr;
        int   e_ov;
        int   e_lvl;
        int   e_tot;
        int   e_in;
        int   e_ovf;
    } vec_t;

    vec_t vt[35];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // push sequence
        vt[0]  = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
        vt[1]  = '{1, 0, 1, 0, 1, 1, 2, 1, 0};
        vt[2]  = '{1, 1, 1, 0, 1, 1, 3, 2, 0};
        vt[3]  = '{0, 0, 1, 0, 0, 0, 3, 2, 0};
        // overflow then drain
        vt[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[5]  = '{1, 1, 0, 0, 1, 1, 1, 1, 0};
        vt[6]  = '{1, 0, 0, 0, 1, 2, 2, 1, 0};
        vt[7]  = '{1, 1, 0, 0, 1, 3, 3, 2, 0};
        vt[8]  = '{1, 0, 0, 0, 1, 4, 4, 2, 0};
        vt[9]  = '{1, 1, 0, 0, 1, 4, 5, 3, 1};
        vt[10] = '{0, 0, 1, 0, 1, 3, 5, 3, 1};
        vt[11] = '{0, 0, 1, 0, 1, 2, 5, 3, 1};
        vt[12] = '{0, 0, 1, 0, 1, 1, 5, 3, 1};
        vt[13] = '{0, 0, 1, 0, 0, 0, 5, 3, 1};
        vt[14] = '{0, 0, 1, 0, 0, 0, 5, 3, 1};
        // push and pop together while full
        vt[15] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[16] = '{1, 0, 0, 0, 1, 1, 1, 0, 0};
        vt[17] = '{1, 0, 0, 0, 1, 2, 2, 0, 0};
        vt[18] = '{1, 0, 0, 0, 1, 3, 3, 0, 0};
        vt[19] = '{1, 0, 0, 0, 1, 4, 4, 0, 0};
        vt[20] = '{1, 1, 1, 0, 1, 4, 5, 1, 0};
        vt[21] = '{0, 0, 1, 0, 1, 3, 5, 1, 0};
        vt[22] = '{0, 0, 1, 0, 1, 2, 5, 1, 0};
        vt[23] = '{0, 0, 1, 0, 1, 1, 5, 1, 0};
        vt[24] = '{0, 0, 1, 0, 0, 0, 5, 1, 0};
        // clear coincident with valid and pop
        vt[25] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[26] = '{1, 0, 0, 0, 1, 1, 1, 0, 0};
        vt[27] = '{1, 0, 0, 0, 1, 2, 2, 0, 0};
        vt[28] = '{1, 0, 0, 0, 1, 3, 3, 0, 0};
        vt[29] = '{1, 0, 0, 0, 1, 4, 4, 0, 0};
        vt[30] = '{1, 0, 0, 0, 1, 4, 5, 0, 1};
        vt[31] = '{0, 0, 1, 0, 1, 3, 5, 0, 1};
        vt[32] = '{0, 0, 1, 0, 1, 2, 5, 0, 1};
        vt[33] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        vt[34] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

        reset = 1'b0;
        valid = 1'b0;
        is_inside = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_idx", out_idx, 0);
        chk("reset_total_cnt", total_cnt, 0);
        chk("reset_inside_cnt", inside_cnt, 0);
        chk("reset_level", level, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 35; i++) begin
            valid = vt[i].v;
            is_inside = vt[i].ins;
            out_ready = vt[i].rdy;
            clear = vt[i].clr;
            step();
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d_level", i), level, vt[i].e_lvl);
            chk($sformatf("vec%0d_total_cnt", i), total_cnt, vt[i].e_tot);
            chk($sformatf("vec%0d_inside_cnt", i), inside_cnt, vt[i].e_in);
            chk($sformatf("vec%0d_overflow", i), overflow, vt[i].e_ovf);
        end

        // index wrap and inside saturation on the narrow instance
        valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        out_ready = 1'b1;
        is_inside = 1'b1;
        valid = 1'b1;
        repeat (17) step();
        chk("wrap_out_valid", w_out_valid, 1);
        chk("wrap_out_idx", w_out_idx, 0);
        chk("wrap_total_cnt", w_total_cnt, 1);
        chk("wrap_inside_cnt", w_inside_cnt, 15);
        chk("wrap_wide_total_cnt", total_cnt, 17);
        valid = 1'b0;
        step();
        chk("wrap_drained_level", w_level, 0);

        // asynchronous reset between edges with three entries stored
        out_ready = 1'b0;
        valid = 1'b1;
        is_inside = 1'b0;
        repeat (3) step();
        valid = 1'b0;
        chk("pre_reset_level", level, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_idx", out_idx, 0);
        chk("async_out_inside", out_inside, 0);
        chk("async_total_cnt", total_cnt, 0);
        chk("async_inside_cnt", inside_cnt, 0);
        chk("async_level", level, 0);
        chk("async_overflow", overflow, 0);
        repeat (2) step();
        reset = 1'b1;
        valid = 1'b1;
        is_inside = 1'b1;
        step();
        valid = 1'b0;
        chk("post_reset_out_valid", out_valid, 1);
        chk("post_reset_out_idx", out_idx, 0);
        chk("post_reset_out_inside", out_inside, 1);
        chk("post_reset_level", level, 1);
        out_ready = 1'b1;
        repeat (2) step();
        chk("final_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
